// File: rtl/ifetch_buf_pkg.sv
// rtl/ifetch_buf_pkg.sv - shared constants, fetch entry layout and address check for ifetch_buf
package ifetch_buf_pkg;

    localparam logic [31:0] PC_INIT     = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR  = 32'h0000_4180;
    localparam logic [4:0]  EXC_NONE    = 5'd0;
    localparam logic [4:0]  EXC_ADEL    = 5'd4;
    localparam logic [31:0] IM_BASE_DEF = PC_INIT;
    localparam int          IM_WORDS_DEF = 4096;
    localparam int          ENTRY_W     = 69;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } fetch_entry_t;

    // Misaligned or outside [base, limit) raises AdEL.
    function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                            input logic [31:0] base,
                                            input logic [31:0] limit);
        return (pc[1:0] != 2'b00) || (pc < base) || (pc >= limit);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous skid FIFO with head look-ahead, clear, push/pop at any fill level
module ifetch_fifo
    import ifetch_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // When full, the head slot is read this cycle before being overwritten at the edge.
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - instruction fetch stage: BRAM issue, in-flight slot, skid FIFO to IF/ID
// Optional perf_bubble/perf_stall counters when IFETCH_PERF_EN is defined.
module ifetch_buf
    import ifetch_buf_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF,
    parameter int          ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_in,
    output logic              pc_en,
    input  logic              flush,
    output logic              im_en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [31:0]       im_rdata,
    input  logic              id_stall,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_instr,
    output logic [4:0]        id_exc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_bubble,
    output logic [31:0]       perf_stall
`endif
);

    localparam int          CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0] IM_LIMIT = IM_BASE + 32'(IM_WORDS) * 32'd4;

    logic             bad, issue, deq;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occ;
    fetch_entry_t     head, push_entry;

    logic             slot_valid_q, slot_valid_d;
    logic [31:0]      slot_pc_q, slot_pc_d;
    logic             slot_bad_q, slot_bad_d;

    always_comb begin
        bad      = fetch_addr_bad(pc_in, IM_BASE, IM_LIMIT);
        id_valid = (count != '0);
        deq      = id_valid & ~id_stall;
        // Occupancy after this edge counts the in-flight word, so its return always has a slot.
        occ      = (CNT_W+1)'(count) + (CNT_W+1)'(slot_valid_q) - (CNT_W+1)'(deq);
        issue    = ~reset & ~flush & (occ < (CNT_W+1)'(DEPTH));
        pc_en    = issue;
        im_en    = issue & ~bad;
        im_addr  = ADDR_W'((pc_in - IM_BASE) >> 2);
    end

    always_comb begin
        slot_valid_d = issue;
        slot_pc_d    = issue ? pc_in : slot_pc_q;
        slot_bad_d   = issue ? bad : slot_bad_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_bad_q   <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_bad_q   <= slot_bad_d;
        end
    end

    always_comb begin
        push_entry.pc    = slot_pc_q;
        push_entry.instr = slot_bad_q ? 32'd0 : im_rdata;
        push_entry.exc   = slot_bad_q ? EXC_ADEL : EXC_NONE;
    end

    // A flush clears the FIFO and overrides the push of the in-flight return.
    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (slot_valid_q),
        .push_data (push_entry),
        .pop       (deq),
        .head_data (head),
        .count     (count)
    );

    always_comb begin
        id_pc    = id_valid ? head.pc    : 32'd0;
        id_instr = id_valid ? head.instr : 32'd0;
        id_exc   = id_valid ? head.exc   : EXC_NONE;
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_bubble_q, perf_bubble_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_bubble_d = perf_bubble_q + {31'd0, ~id_valid};
        perf_stall_d  = perf_stall_q + {31'd0, id_valid & id_stall};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bubble_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_bubble_q <= perf_bubble_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_bubble = perf_bubble_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
